// File: rtl/print_screen.sv
// rtl/print_screen.sv - UART frame server: each valid request byte on RxD snapshots packet
// and streams it on TxD as PKT_BYTES 8N1 bytes, MSB byte first.
module print_screen #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 115_200,
  parameter int PKT_BYTES = 22
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   RxD,
  input  logic [8*PKT_BYTES-1:0] packet,
  output logic                   TxD,
  output logic                   busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int PKT_W        = 8 * PKT_BYTES;
  localparam int CNT_W        = ($clog2(CLKS_PER_BIT) > 0) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BYTE_W       = ($clog2(PKT_BYTES) > 0) ? $clog2(PKT_BYTES) : 1;

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(PKT_BYTES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic             rxd_meta;
  logic             rxd_sync;
  logic             rxd_prev;
  logic [1:0]       rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic             rx_accept;

  logic [PKT_W-1:0]  snap;
  logic [7:0]        tx_byte;
  logic [1:0]        tx_state;
  logic [CNT_W-1:0]  tx_cnt;
  logic [2:0]        tx_bit;
  logic [BYTE_W-1:0] tx_idx;
  logic              tx_go;

  // Any byte with a good stop bit is a request; the data value itself is never needed.
  assign rx_accept = (rx_state == ST_STOP) && (rx_cnt == BIT_LAST) && rxd_sync && !busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
    end else begin
      rxd_meta <= RxD;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      case (rx_state)
        ST_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
          if (rxd_prev && !rxd_sync) rx_state <= ST_START;
        end
        ST_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_state <= rxd_sync ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= ST_STOP;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        default: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= ST_IDLE;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // tx_go delays the first start bit by one cycle so it lands 2 cycles after the request sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap     <= '0;
      tx_byte  <= '0;
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_idx   <= '0;
      tx_go    <= 1'b0;
      busy     <= 1'b0;
      TxD      <= 1'b1;
    end else begin
      tx_go <= 1'b0;
      if (rx_accept) begin
        snap  <= packet;
        busy  <= 1'b1;
        tx_go <= 1'b1;
      end
      case (tx_state)
        ST_IDLE: begin
          if (tx_go) begin
            tx_state <= ST_START;
            TxD      <= 1'b0;
            tx_byte  <= snap[PKT_W-1 -: 8];
            snap     <= {snap[PKT_W-9:0], 8'h00};
            tx_idx   <= '0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
          end
        end
        ST_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= ST_DATA;
            TxD      <= tx_byte[0];
            tx_byte  <= {1'b0, tx_byte[7:1]};
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= ST_STOP;
              TxD      <= 1'b1;
            end else begin
              tx_bit  <= tx_bit + 3'd1;
              TxD     <= tx_byte[0];
              tx_byte <= {1'b0, tx_byte[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        default: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_idx == BYTE_LAST) begin
              tx_state <= ST_IDLE;
              busy     <= 1'b0;
            end else begin
              tx_idx   <= tx_idx + BYTE_W'(1);
              tx_state <= ST_START;
              tx_bit   <= '0;
              TxD      <= 1'b0;
              tx_byte  <= snap[PKT_W-1 -: 8];
              snap     <= {snap[PKT_W-9:0], 8'h00};
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_print_screen.sv
// tb/tb_print_screen.sv - directed scoreboard bench for print_screen at 32 clocks per bit.
module tb_print_screen;

  localparam int CLK_FREQ  = 3_200_000;
  localparam int BAUD      = 100_000;
  localparam int PKT_BYTES = 22;
  localparam int CPB       = CLK_FREQ / BAUD;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         RxD;
  logic [175:0] packet;
  logic         TxD;
  logic         busy;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  print_screen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .PKT_BYTES(PKT_BYTES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RxD   (RxD),
    .packet(packet),
    .TxD   (TxD),
    .busy  (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected bytes are queued from the packet present when the request is sent.
  task automatic send_byte(input logic [7:0] d, input logic stop, input bit accept);
    if (accept)
      for (int i = 0; i < PKT_BYTES; i++) sb.push_back(packet[8*(PKT_BYTES-1-i) +: 8]);
    RxD = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = d[i];
      repeat (CPB) @(negedge clk);
    end
    RxD = stop;
    repeat (CPB) @(negedge clk);
    RxD = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle_window(input string tag, input int n);
    logic bad = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (TxD !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    chk(tag, {31'd0, bad}, 32'd0);
  endtask

  task automatic wait_busy(input string tag);
    int t = 0;
    while (busy !== 1'b1 && t < 20*CPB) begin
      @(negedge clk);
      t++;
    end
    chk(tag, {31'd0, busy}, 32'd1);
  endtask

  task automatic check_frame(input string tag);
    int         t       = 0;
    int         busy_at = -1;
    int         k;
    logic [7:0] eb;
    logic       eb_bit;
    while (t < 20*CPB) begin
      @(negedge clk);
      t++;
      if (busy_at < 0 && busy === 1'b1) busy_at = t;
      if (TxD === 1'b0) break;
    end
    chk({tag, "_start"}, {31'd0, TxD}, 32'd0);
    if (TxD !== 1'b0) return;
    chk({tag, "_latency"}, t - busy_at, 32'd1);
    for (int b = 0; b < PKT_BYTES; b++) begin
      chk({tag, "_sb_avail"}, {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() == 0) return;
      eb = sb.pop_front();
      for (int n = 0; n < 10*CPB; n++) begin
        if (b > 0 || n > 0) @(negedge clk);
        k = n / CPB;
        if (n % CPB == 0 || n % CPB == CPB-1) begin
          eb_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : eb[k-1];
          chk($sformatf("%s_byte%0d_bit%0d_off%0d", tag, b, k, n % CPB), {31'd0, TxD}, {31'd0, eb_bit});
        end
      end
    end
    chk({tag, "_busy_last_cycle"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk({tag, "_end_txd"}, {31'd0, TxD}, 32'd1);
    chk({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    RxD   = 1'b1;
    for (int i = 0; i < PKT_BYTES; i++)
      packet[8*(PKT_BYTES-1-i) +: 8] = (i == 0) ? 8'hA5 : (i == PKT_BYTES-1) ? 8'h5A : 8'(i);

    #2 rst_n = 1'b0;
    #1;
    chk("reset_async_txd", {31'd0, TxD}, 32'd1);
    chk("reset_async_busy", {31'd0, busy}, 32'd0);
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_txd", {31'd0, TxD}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    idle_window("reset_idle_10000", 10000);

    fork
      send_byte(8'h52, 1'b1, 1'b1);
      check_frame("single");
    join
    chk("single_sb_empty", sb.size(), 32'd0);

    fork
      send_byte(8'h52, 1'b1, 1'b1);
      check_frame("hold");
      begin
        wait_busy("hold_busy_rise");
        repeat (100) @(negedge clk);
        packet = '1;
      end
    join
    chk("hold_sb_empty", sb.size(), 32'd0);
    for (int i = 0; i < PKT_BYTES; i++)
      packet[8*(PKT_BYTES-1-i) +: 8] = 8'(8'h30 + 8'(i * 7));

    fork
      check_frame("busy_req");
      begin
        send_byte(8'h52, 1'b1, 1'b1);
        repeat (49*CPB) @(negedge clk);
        send_byte(8'h52, 1'b1, 1'b0);
      end
    join
    idle_window("no_second_frame", 30*CPB);
    chk("busy_req_sb_empty", sb.size(), 32'd0);

    send_byte(8'h52, 1'b0, 1'b0);
    idle_window("bad_stop_bit", 20*CPB);
    RxD = 1'b0;
    repeat (10) @(negedge clk);
    RxD = 1'b1;
    idle_window("rx_glitch", 20*CPB);

    send_byte(8'hC3, 1'b1, 1'b1);
    repeat (103*CPB) @(negedge clk);
    chk("midframe_busy_before_reset", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_txd", {31'd0, TxD}, 32'd1);
    chk("midframe_reset_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle_window("post_reset_idle", 4*CPB);
    for (int i = 0; i < PKT_BYTES; i++)
      packet[8*(PKT_BYTES-1-i) +: 8] = 8'($urandom_range(0, 255));
    fork
      send_byte(8'h52, 1'b1, 1'b1);
      check_frame("after_reset");
    join
    chk("after_reset_sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
